llc_cmd_frontend: RTL and testbench
===================================

Name: llc_cmd_frontend

Overview:
- Upstream stage of the LLC controller: accepts trace commands (code + 32-bit address), validates and decodes them, and splits the address into tag/index/offset.
- Buffers decoded requests in a small in-order FIFO.
- Presents requests to the cache controller over a valid/ready handshake.
- Drops and counts illegal command codes.

Parameters:
- FIFO_DEPTH, 4, number of buffered decoded requests (power of two, >=2)
- CNT_WIDTH, 16, width of the statistics counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  trace command present
- cmd_ready  out  1  frontend can accept a command
- cmd_code  in  4  trace command code (0-6, 8, 9 legal)
- cmd_addr  in  32  byte address
- req_valid  out  1  decoded request at FIFO head
- req_ready  in  1  cache controller consumes head
- req_kind  out  4  req_kind_t of head
- req_tag  out  12  head address[31:20]
- req_index  out  14  head address[19:6]
- req_offset  out  6  head address[5:0]
- req_is_snoop  out  1  head kind is 3..6
- illegal_pulse  out  1  one-cycle strobe when an illegal code is accepted
- accepted_cnt  out  CNT_WIDTH  legal commands enqueued (saturating)
- illegal_cnt  out  CNT_WIDTH  illegal commands dropped (saturating)

Behaviour:
- Reset (async, rst_n=0): FIFO empty; cmd_ready=0 while in reset and 1 from the first clock after release; req_valid=0; req_kind, req_tag, req_index, req_offset and req_is_snoop=0; illegal_pulse=0; both counters=0.
- Accept: the handshake fires on cmd_valid && cmd_ready. cmd_ready = !full, with no pass-through when full, even if req_ready=1 that cycle.
- Legal codes 0-6, 8, 9: decode and push {kind, tag, index, offset, is_snoop}. accepted_cnt increments.
- Illegal codes 7, 10-15: the handshake completes and the command is consumed. Nothing is pushed. illegal_pulse=1 on the next cycle; illegal_cnt increments.
- Codes 8 (CLEAR) and 9 (PRINT): enqueued in order like other requests, with the address fields carried unchanged. The controller ignores the address.
- Latency: a command accepted at edge N appears with req_valid=1 after edge N (registered). There is no combinational path from cmd_* to req_*.
- Dequeue: fires on req_valid && req_ready; the head advances at that edge.
- req_* outputs are stable while req_valid=1 and req_ready=0.
- When req_valid=0, req_* hold their last value and are don't-care for the controller.
- Simultaneous push and pop when not full and not empty: occupancy is unchanged and order is preserved.
- Simultaneous push and pop when empty: the push lands and the pop is not possible (req_valid=0).
- Full: cmd_ready=0 until a pop. cmd_ready rises the cycle after the pop edge.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH. full/empty are derived from MSB/LSB comparison.
- Counters saturate at all-ones and never wrap.
- Reset mid-operation: all buffered requests are discarded immediately and counters are cleared.

Decomposition:
- Shared package (alongside the cache config constants):
  - req_kind_t: enum logic[3:0] with CPU_RD_D=0, CPU_WR_D=1, CPU_RD_I=2, SNP_RD=3, SNP_WR=4, SNP_RWIM=5, SNP_INV=6, CLR_RST=8, PRINT=9.
  - Packed struct cache_req_t {kind, tag, index, offset, is_snoop}.
  - Constants ADDR_BITS=32 and the TAG/INDEX/OFFSET bit positions derived from BLOCK_OFFSET_BITS and INDEX_BITS.
- One sub-module: req_fifo, a generic synchronous FIFO of cache_req_t with push/pop/full/empty.
- Decode, legality checking and counters stay in the top module.

Test Plan:
- Reset then a single command code=0, addr=0x1234_5678 with req_ready=1 -> next cycle req_valid=1, kind=0, tag=0x123, index=0x1159, offset=0x38, is_snoop=0; accepted_cnt=1.
- req_ready=0, push 4 commands (codes 1,3,5,9) -> cmd_ready=0 after the 4th; a 5th command is stalled. Raise req_ready -> outputs appear in order 1,3,5,9 with is_snoop 0,1,1,0, and cmd_ready returns the cycle after the first pop.
- code=7 then code=15 -> both are accepted with no enqueue, illegal_pulse fires twice, illegal_cnt=2, req_valid stays 0.
- Continuous streaming with req_ready=1 and 20 back-to-back legal commands -> throughput 1/cycle, occupancy never exceeds 1, order is preserved, and addresses are split correctly for addr=0xFFFF_FFFF (tag=0xFFF, index=0x3FFF, offset=0x3F).
- Reset asserted with 3 entries buffered -> req_valid=0 and counters=0 immediately (asynchronously). After release, the next command appears alone.
- Force accepted_cnt to 0xFFFE, then send 3 legal commands -> the count saturates at 0xFFFF.

Source files
------------

// File: rtl/llc_cmd_frontend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : llc_cmd_frontend_pkg
// Description : Shared LLC types and constants. Holds the address split
//               (tag/index/offset), the decoded request kind, the decoded
//               request record, and helper functions for legality checking
//               and decoding.
// Revision    : 1.0 - initial release
// ============================================================================
package llc_cmd_frontend_pkg;

  // Cache geometry
  localparam int ADDR_BITS         = 32;
  localparam int BLOCK_OFFSET_BITS = 6;
  localparam int INDEX_BITS        = 14;
  localparam int TAG_BITS          = ADDR_BITS - INDEX_BITS - BLOCK_OFFSET_BITS;

  localparam int OFFSET_LSB = 0;
  localparam int OFFSET_MSB = BLOCK_OFFSET_BITS - 1;
  localparam int INDEX_LSB  = BLOCK_OFFSET_BITS;
  localparam int INDEX_MSB  = BLOCK_OFFSET_BITS + INDEX_BITS - 1;
  localparam int TAG_LSB    = BLOCK_OFFSET_BITS + INDEX_BITS;
  localparam int TAG_MSB    = ADDR_BITS - 1;

  typedef enum logic [3:0] {
    CPU_RD_D = 4'd0,
    CPU_WR_D = 4'd1,
    CPU_RD_I = 4'd2,
    SNP_RD   = 4'd3,
    SNP_WR   = 4'd4,
    SNP_RWIM = 4'd5,
    SNP_INV  = 4'd6,
    CLR_RST  = 4'd8,
    PRINT    = 4'd9
  } req_kind_t;

  typedef struct packed {
    req_kind_t                     kind;
    logic [TAG_BITS-1:0]           tag;
    logic [INDEX_BITS-1:0]         index;
    logic [BLOCK_OFFSET_BITS-1:0]  offset;
    logic                          is_snoop;
  } cache_req_t;

  // Codes 7 and 10..15 are not defined trace commands.
  function automatic logic code_is_legal(input logic [3:0] code);
    return (code <= 4'd6) || (code == 4'd8) || (code == 4'd9);
  endfunction

  // CLEAR/PRINT carry their address fields through untouched like any other
  // request; the controller simply ignores them for those kinds.
  function automatic cache_req_t decode_cmd(input logic [3:0]           code,
                                            input logic [ADDR_BITS-1:0] addr);
    cache_req_t r;
    r.kind     = req_kind_t'(code);
    r.tag      = addr[TAG_MSB:TAG_LSB];
    r.index    = addr[INDEX_MSB:INDEX_LSB];
    r.offset   = addr[OFFSET_MSB:OFFSET_LSB];
    r.is_snoop = (code >= 4'd3) && (code <= 4'd6);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/llc_cmd_frontend_if.sv
`default_nettype none
// ============================================================================
// Module      : llc_cmd_frontend_if
// Description : Bundle of the frontend's trace-command channel, decoded
//               request channel and statistics outputs.
//   master : trace source / cache controller side (drives cmd_*, req_ready)
//   slave  : frontend side (drives cmd_ready, req_*, statistics)
// Revision    : 1.0 - initial release
// ============================================================================
interface llc_cmd_frontend_if #(
  parameter int CNT_WIDTH = 16
);
  import llc_cmd_frontend_pkg::*;

  // Trace command channel
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [3:0]                    cmd_code;
  logic [ADDR_BITS-1:0]          cmd_addr;

  // Decoded request channel
  logic                          req_valid;
  logic                          req_ready;
  req_kind_t                     req_kind;
  logic [TAG_BITS-1:0]           req_tag;
  logic [INDEX_BITS-1:0]         req_index;
  logic [BLOCK_OFFSET_BITS-1:0]  req_offset;
  logic                          req_is_snoop;

  // Statistics
  logic                          illegal_pulse;
  logic [CNT_WIDTH-1:0]          accepted_cnt;
  logic [CNT_WIDTH-1:0]          illegal_cnt;

  modport master (
    output cmd_valid, cmd_code, cmd_addr, req_ready,
    input  cmd_ready, req_valid, req_kind, req_tag, req_index, req_offset,
           req_is_snoop, illegal_pulse, accepted_cnt, illegal_cnt
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_addr, req_ready,
    output cmd_ready, req_valid, req_kind, req_tag, req_index, req_offset,
           req_is_snoop, illegal_pulse, accepted_cnt, illegal_cnt
  );

endinterface
`default_nettype wire

// File: rtl/llc_cmd_frontend_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : req_fifo
// Description : Synchronous in-order FIFO of cache_req_t. Pointers are one
//               bit wider than the address so full/empty come from an
//               MSB/LSB comparison. Push when full and pop when empty are
//               ignored.
//   clk, rst_n         : clock, asynchronous active-low reset
//   i_push, i_wdata    : write strobe and entry
//   i_pop              : advance head
//   o_rdata            : head entry (valid while !o_empty)
//   o_full, o_empty    : occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module req_fifo
  import llc_cmd_frontend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       i_push,
  input  wire cache_req_t i_wdata,
  input  wire logic       i_pop,
  output cache_req_t      o_rdata,
  output logic            o_full,
  output logic            o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  cache_req_t  r_mem [DEPTH];

  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read once it has been written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/llc_cmd_frontend.sv
`default_nettype none
// ============================================================================
// Module      : llc_cmd_frontend
// Description : LLC trace-command frontend. Accepts {code, address},
//               drops and counts illegal codes, decodes legal ones into
//               {kind, tag, index, offset, is_snoop} and buffers them in an
//               in-order FIFO presented over a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command channel, request channel and statistics (slave)
// Revision    : 1.0 - initial release
// ============================================================================
module llc_cmd_frontend
  import llc_cmd_frontend_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  llc_cmd_frontend_if.slave bus
);

  logic                 r_ready_en;
  logic                 r_illegal_pulse;
  logic [CNT_WIDTH-1:0] r_accepted_cnt;
  logic [CNT_WIDTH-1:0] r_illegal_cnt;
  cache_req_t           r_hold;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_cmd_fire;
  logic                 w_legal;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  cache_req_t           w_wdata;
  cache_req_t           w_head;
  cache_req_t           w_out;

  // No pass-through when full: a pop in the same cycle does not open a slot.
  assign bus.cmd_ready = r_ready_en && !w_full;
  assign w_cmd_fire    = bus.cmd_valid && bus.cmd_ready;
  assign w_legal       = code_is_legal(bus.cmd_code);
  assign w_push        = w_cmd_fire && w_legal;
  assign w_drop        = w_cmd_fire && !w_legal;
  assign w_wdata       = decode_cmd(bus.cmd_code, bus.cmd_addr);
  assign w_pop         = !w_empty && bus.req_ready;

  req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // cmd_ready stays low in reset and rises on the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready_en <= 1'b0;
    else        r_ready_en <= 1'b1;
  end

  // r_hold keeps the most recently popped head so req_* hold their last
  // value once the FIFO drains, instead of showing a stale storage slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold          <= '0;
      r_illegal_pulse <= 1'b0;
      r_accepted_cnt  <= '0;
      r_illegal_cnt   <= '0;
    end else begin
      if (w_pop) r_hold <= w_head;
      r_illegal_pulse <= w_drop;
      if (w_push && (r_accepted_cnt != '1))
        r_accepted_cnt <= r_accepted_cnt + CNT_WIDTH'(1);
      if (w_drop && (r_illegal_cnt != '1))
        r_illegal_cnt <= r_illegal_cnt + CNT_WIDTH'(1);
    end
  end

  assign w_out             = w_empty ? r_hold : w_head;
  assign bus.req_valid     = !w_empty;
  assign bus.req_kind      = w_out.kind;
  assign bus.req_tag       = w_out.tag;
  assign bus.req_index     = w_out.index;
  assign bus.req_offset    = w_out.offset;
  assign bus.req_is_snoop  = w_out.is_snoop;
  assign bus.illegal_pulse = r_illegal_pulse;
  assign bus.accepted_cnt  = r_accepted_cnt;
  assign bus.illegal_cnt   = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_llc_cmd_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_llc_cmd_frontend
// Description : Self-checking bench for llc_cmd_frontend. Directed vector
//               table, streaming and random phases against a queue-based
//               reference model, a mid-operation reset sequence, and a
//               counter saturation check on a narrow-counter instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llc_cmd_frontend;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  llc_cmd_frontend_if #(.CNT_WIDTH(16)) ifc ();
  llc_cmd_frontend_if #(.CNT_WIDTH(2))  ifs ();

  llc_cmd_frontend #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  llc_cmd_frontend #(.FIFO_DEPTH(2), .CNT_WIDTH(2)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifs)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int kind;
    int tag;
    int idx;
    int off;
    int snp;
  } exp_t;

  exp_t m_q[$];
  exp_t m_last;
  int   m_acc;
  int   m_ill;
  bit   m_pulse;
  bit   m_rdy_en;

  function automatic bit m_legal(input int code);
    return (code <= 6) || (code == 8) || (code == 9);
  endfunction

  function automatic exp_t m_decode(input int code, input logic [31:0] addr);
    exp_t e;
    longint unsigned a;
    a     = addr;
    e.kind = code;
    e.tag  = int'(a / 1048576);
    e.idx  = int'((a / 64) % 16384);
    e.off  = int'(a % 64);
    e.snp  = (code >= 3 && code <= 6) ? 1 : 0;
    return e;
  endfunction

  task automatic m_clear();
    m_q.delete();
    m_last  = '{0, 0, 0, 0, 0};
    m_acc   = 0;
    m_ill   = 0;
    m_pulse = 0;
    m_rdy_en = 0;
  endtask

  task automatic check_model();
    exp_t h;
    h = (m_q.size() > 0) ? m_q[0] : m_last;
    chk("cmd_ready", ifc.cmd_ready, (m_rdy_en && m_q.size() < DEPTH) ? 1 : 0);
    chk("req_valid", ifc.req_valid, (m_q.size() > 0) ? 1 : 0);
    chk("req_kind", ifc.req_kind, h.kind);
    chk("req_tag", ifc.req_tag, h.tag);
    chk("req_index", ifc.req_index, h.idx);
    chk("req_offset", ifc.req_offset, h.off);
    chk("req_is_snoop", ifc.req_is_snoop, h.snp);
    chk("illegal_pulse", ifc.illegal_pulse, m_pulse);
    chk("accepted_cnt", ifc.accepted_cnt, m_acc);
    chk("illegal_cnt", ifc.illegal_cnt, m_ill);
  endtask

  // Drive one cycle of inputs, clock it, advance the model, compare.
  task automatic cycle(input logic v, input logic [3:0] code,
                       input logic [31:0] addr, input logic rr);
    bit fire, pop;
    ifc.cmd_valid = v;
    ifc.cmd_code  = code;
    ifc.cmd_addr  = addr;
    ifc.req_ready = rr;
    fire = v && m_rdy_en && (m_q.size() < DEPTH);
    pop  = rr && (m_q.size() > 0);
    @(posedge clk);
    #1;
    if (pop) m_last = m_q.pop_front();
    m_pulse = 0;
    if (fire) begin
      if (m_legal(int'(code))) begin
        m_q.push_back(m_decode(int'(code), addr));
        if (m_acc < 65535) m_acc++;
      end else begin
        if (m_ill < 65535) m_ill++;
        m_pulse = 1;
      end
    end
    m_rdy_en = 1;
    check_model();
  endtask

  task automatic do_reset();
    ifc.cmd_valid = 1'b0;
    ifc.req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst req_valid", ifc.req_valid, 0);
    chk("rst cmd_ready", ifc.cmd_ready, 0);
    chk("rst accepted_cnt", ifc.accepted_cnt, 0);
    chk("rst illegal_cnt", ifc.illegal_cnt, 0);
    chk("rst illegal_pulse", ifc.illegal_pulse, 0);
    chk("rst req_tag", ifc.req_tag, 0);
    chk("rst req_kind", ifc.req_kind, 0);
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel cmd_ready", ifc.cmd_ready, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [3:0]  code;
    logic [31:0] addr;
    logic        rr;
    logic        e_valid;
    logic [3:0]  e_kind;
    logic [11:0] e_tag;
    logic [13:0] e_idx;
    logic [5:0]  e_off;
    logic        e_snp;
    logic        e_rdy;
    logic        e_pulse;
    int          e_acc;
    int          e_ill;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [3:0]  c;
    logic [31:0] a;
    int          n;

    tbl[0]  = '{1'b1, 4'd0,  32'h1234_5678, 1'b1, 1'b1, 4'd0, 12'h123, 14'h1159, 6'h38, 1'b0, 1'b1, 1'b0, 1, 0};
    tbl[1]  = '{1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 4'd0, 12'h123, 14'h1159, 6'h38, 1'b0, 1'b1, 1'b0, 1, 0};
    tbl[2]  = '{1'b1, 4'd1,  32'h0010_0041, 1'b0, 1'b1, 4'd1, 12'h001, 14'h0001, 6'h01, 1'b0, 1'b1, 1'b0, 2, 0};
    tbl[3]  = '{1'b1, 4'd3,  32'h0020_0082, 1'b0, 1'b1, 4'd1, 12'h001, 14'h0001, 6'h01, 1'b0, 1'b1, 1'b0, 3, 0};
    tbl[4]  = '{1'b1, 4'd5,  32'h0030_00C3, 1'b0, 1'b1, 4'd1, 12'h001, 14'h0001, 6'h01, 1'b0, 1'b1, 1'b0, 4, 0};
    tbl[5]  = '{1'b1, 4'd9,  32'h0040_0104, 1'b0, 1'b1, 4'd1, 12'h001, 14'h0001, 6'h01, 1'b0, 1'b0, 1'b0, 5, 0};
    tbl[6]  = '{1'b1, 4'd2,  32'h0050_0145, 1'b0, 1'b1, 4'd1, 12'h001, 14'h0001, 6'h01, 1'b0, 1'b0, 1'b0, 5, 0};
    tbl[7]  = '{1'b1, 4'd2,  32'h0050_0145, 1'b1, 1'b1, 4'd3, 12'h002, 14'h0002, 6'h02, 1'b1, 1'b1, 1'b0, 5, 0};
    tbl[8]  = '{1'b1, 4'd2,  32'h0050_0145, 1'b1, 1'b1, 4'd5, 12'h003, 14'h0003, 6'h03, 1'b1, 1'b1, 1'b0, 6, 0};
    tbl[9]  = '{1'b0, 4'd0,  32'h0,         1'b1, 1'b1, 4'd9, 12'h004, 14'h0004, 6'h04, 1'b0, 1'b1, 1'b0, 6, 0};
    tbl[10] = '{1'b0, 4'd0,  32'h0,         1'b1, 1'b1, 4'd2, 12'h005, 14'h0005, 6'h05, 1'b0, 1'b1, 1'b0, 6, 0};
    tbl[11] = '{1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 4'd2, 12'h005, 14'h0005, 6'h05, 1'b0, 1'b1, 1'b0, 6, 0};
    tbl[12] = '{1'b1, 4'd7,  32'hDEAD_BEEF, 1'b1, 1'b0, 4'd2, 12'h005, 14'h0005, 6'h05, 1'b0, 1'b1, 1'b1, 6, 1};
    tbl[13] = '{1'b1, 4'd15, 32'hCAFE_F00D, 1'b1, 1'b0, 4'd2, 12'h005, 14'h0005, 6'h05, 1'b0, 1'b1, 1'b1, 6, 2};
    tbl[14] = '{1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 4'd2, 12'h005, 14'h0005, 6'h05, 1'b0, 1'b1, 1'b0, 6, 2};

    ifc.cmd_valid = 1'b0;
    ifc.cmd_code  = 4'd0;
    ifc.cmd_addr  = 32'h0;
    ifc.req_ready = 1'b0;
    ifs.cmd_valid = 1'b0;
    ifs.cmd_code  = 4'd0;
    ifs.cmd_addr  = 32'h0;
    ifs.req_ready = 1'b1;

    #2;
    do_reset();
    cycle(1'b0, 4'd0, 32'h0, 1'b0);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].v, tbl[i].code, tbl[i].addr, tbl[i].rr);
      chk($sformatf("tbl%0d req_valid", i), ifc.req_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d req_kind", i), ifc.req_kind, tbl[i].e_kind);
      chk($sformatf("tbl%0d req_tag", i), ifc.req_tag, tbl[i].e_tag);
      chk($sformatf("tbl%0d req_index", i), ifc.req_index, tbl[i].e_idx);
      chk($sformatf("tbl%0d req_offset", i), ifc.req_offset, tbl[i].e_off);
      chk($sformatf("tbl%0d req_is_snoop", i), ifc.req_is_snoop, tbl[i].e_snp);
      chk($sformatf("tbl%0d cmd_ready", i), ifc.cmd_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d illegal_pulse", i), ifc.illegal_pulse, tbl[i].e_pulse);
      chk($sformatf("tbl%0d accepted_cnt", i), ifc.accepted_cnt, tbl[i].e_acc);
      chk($sformatf("tbl%0d illegal_cnt", i), ifc.illegal_cnt, tbl[i].e_ill);
    end

    // Back-to-back legal stream with the consumer always ready
    for (int i = 0; i < 20; i++) begin
      n = int'($urandom_range(0, 8));
      c = (n == 7) ? 4'd8 : (n == 8) ? 4'd9 : 4'(n);
      a = (i == 19) ? 32'hFFFF_FFFF : $urandom;
      cycle(1'b1, c, a, 1'b1);
      chk("stream occupancy<=1", (m_q.size() <= 1) ? 1 : 0, 1);
      chk("stream req_valid", ifc.req_valid, 1);
    end
    chk("ones tag", ifc.req_tag, 12'hFFF);
    chk("ones index", ifc.req_index, 14'h3FFF);
    chk("ones offset", ifc.req_offset, 6'h3F);

    // Random traffic with backpressure
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 4'($urandom_range(0, 15)), $urandom,
            ($urandom % 3) != 0);
    end

    // Reset with entries buffered
    repeat (5) cycle(1'b0, 4'd0, 32'h0, 1'b1);
    cycle(1'b1, 4'd0, 32'h0000_1000, 1'b0);
    cycle(1'b1, 4'd4, 32'h0000_2000, 1'b0);
    cycle(1'b1, 4'd8, 32'h0000_3000, 1'b0);
    chk("pre-reset occupancy", m_q.size(), 3);
    do_reset();
    cycle(1'b0, 4'd0, 32'h0, 1'b0);
    cycle(1'b1, 4'd6, 32'hA5A5_5A5A, 1'b0);
    chk("post-reset single valid", ifc.req_valid, 1);
    chk("post-reset single kind", ifc.req_kind, 6);
    cycle(1'b0, 4'd0, 32'h0, 1'b1);
    chk("post-reset drained", ifc.req_valid, 0);

    // Saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      ifs.cmd_valid = 1'b1;
      ifs.cmd_code  = 4'(i);
      ifs.cmd_addr  = $urandom;
      @(posedge clk);
      #1;
      chk("sat accepted_cnt", ifs.accepted_cnt, (i + 1 > 3) ? 3 : i + 1);
    end
    for (int i = 0; i < 5; i++) begin
      ifs.cmd_valid = 1'b1;
      ifs.cmd_code  = (i == 0) ? 4'd7 : 4'(9 + i);
      @(posedge clk);
      #1;
      chk("sat illegal_cnt", ifs.illegal_cnt, (i + 1 > 3) ? 3 : i + 1);
      chk("sat accepted hold", ifs.accepted_cnt, 3);
    end
    ifs.cmd_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
